// File: rtl/cond_unit.sv
// cond_unit: execute-stage ARM condition check, NZCV flags, branch-shadow
// squash and a one-entry valid/ready output stage. Option: COND_STATS_EN.
module cond_unit #(
  parameter int SHADOW = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flagW,
  input  logic             PCS,
  input  logic             regW,
  input  logic             memW,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             cond_ex,
  output logic [3:0]       flags
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
`endif
);

  logic       n, z, c, v;
  logic       pass;
  logic       squash;
  logic       ex;
  logic       accept;
  logic [1:0] shadow_q;

  assign {n, z, c, v} = flags;
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign squash   = (shadow_q != 2'd0);
  assign ex       = pass & !squash;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c & !z;
      4'b1001: pass = !c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      4'b1111: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags     <= 4'b0000;
      out_valid <= 1'b0;
      PCSrc     <= 1'b0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
      cond_ex   <= 1'b0;
      shadow_q  <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      cond_ex   <= ex;
      PCSrc     <= PCS & ex;
      RegWrite  <= regW & ex;
      MemWrite  <= memW & ex;
      if (ex & flagW[1]) flags[3:2] <= alu_flags[3:2];
      if (ex & flagW[0]) flags[1:0] <= alu_flags[1:0];
      // a squashed branch must not re-arm the shadow
      if (squash)          shadow_q <= shadow_q - 2'd1;
      else if (PCS & ex)   shadow_q <= 2'(SHADOW);
    end else if (out_ready & out_valid) begin
      out_valid <= 1'b0;
      cond_ex   <= 1'b0;
      PCSrc     <= 1'b0;
      RegWrite  <= 1'b0;
      MemWrite  <= 1'b0;
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_count <= '0;
      skip_count <= '0;
    end else if (accept) begin
      if (ex) begin
        if (exec_count != '1) exec_count <= exec_count + CNT_W'(1);
      end else begin
        if (skip_count != '1) skip_count <= skip_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed table, hand sequences and random stimulus for
// cond_unit, checked against a flag/shadow reference model.
module tb_cond_unit;
  localparam int SH = 1;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    cond = 4'h0;
  logic [3:0]    alu_flags = 4'h0;
  logic [1:0]    flagW = 2'b00;
  logic          PCS = 1'b0;
  logic          regW = 1'b0;
  logic          memW = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          PCSrc;
  logic          RegWrite;
  logic          MemWrite;
  logic          cond_ex;
  logic [3:0]    flags;
`ifdef COND_STATS_EN
  logic [CW-1:0] exec_count;
  logic [CW-1:0] skip_count;
`endif

  cond_unit #(.SHADOW(SH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .alu_flags(alu_flags), .flagW(flagW),
    .PCS(PCS), .regW(regW), .memW(memW),
    .out_valid(out_valid), .out_ready(out_ready),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .cond_ex(cond_ex), .flags(flags)
`ifdef COND_STATS_EN
    , .exec_count(exec_count), .skip_count(skip_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [3:0] m_flags;
  logic       m_ov, m_pcs, m_rw, m_mw, m_cex;
  int         m_sq;
  int         m_exec, m_skip;

  typedef struct {
    logic       v;
    logic       r;
    logic [3:0] c;
    logic [3:0] a;
    logic [1:0] fw;
    logic       p;
    logic       rw;
    logic       mw;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Conditions come in complementary pairs; odd codes invert the even one.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b0 : (base ^ c[0]);
  endfunction

  function automatic logic [8:0] outs();
    return {out_valid, PCSrc, RegWrite, MemWrite, cond_ex, flags};
  endfunction

  function automatic logic [8:0] m_outs();
    return {m_ov, m_pcs, m_rw, m_mw, m_cex, m_flags};
  endfunction

  task automatic model_reset();
    m_flags = 4'h0;
    {m_ov, m_pcs, m_rw, m_mw, m_cex} = 5'b0;
    m_sq = 0;
    m_exec = 0;
    m_skip = 0;
  endtask

  // Called at posedge+1; presents inputs and returns at the next posedge+1.
  task automatic apply(input logic v, input logic r, input logic [3:0] c,
                       input logic [3:0] a, input logic [1:0] fw,
                       input logic p, input logic rw, input logic mw);
    bit acc, ex;
    in_valid = v; out_ready = r; cond = c; alu_flags = a;
    flagW = fw; PCS = p; regW = rw; memW = mw;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_ov || r));
    acc = v && (!m_ov || r);
    ex = cond_ok(c, m_flags) && (m_sq == 0);
    @(posedge clk);
    if (acc) begin
      m_ov = 1'b1; m_cex = ex;
      m_pcs = p && ex; m_rw = rw && ex; m_mw = mw && ex;
      if (ex && fw[1]) m_flags[3:2] = a[3:2];
      if (ex && fw[0]) m_flags[1:0] = a[1:0];
      if (m_sq > 0) m_sq--;
      else if (p && ex) m_sq = SH;
      if (ex) m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
      else    m_skip = (m_skip < CMAX) ? m_skip + 1 : CMAX;
    end else if (r && m_ov) begin
      {m_ov, m_pcs, m_rw, m_mw, m_cex} = 5'b0;
    end
    #1;
    check("outputs", 32'(outs()), 32'(m_outs()));
`ifdef COND_STATS_EN
    check("exec_count", 32'(exec_count), 32'(m_exec));
    check("skip_count", 32'(skip_count), 32'(m_skip));
`endif
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b1, 4'hE, 4'h6, 2'b11, 1'b0, 1'b1, 1'b0, 9'b1_0_1_0_1_0110},
      '{1'b1, 1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 9'b1_0_0_0_1_0100},
      '{1'b1, 1'b1, 4'h1, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 9'b1_0_0_0_0_0100},
      '{1'b1, 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 9'b1_0_1_1_1_0100},
      '{1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 9'b1_1_0_0_1_0100},
      '{1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 9'b1_0_0_0_0_0100},
      '{1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b1_0_1_0_1_0100},
      '{1'b1, 1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b1_0_0_0_0_0100},
      '{1'b1, 1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b1_0_0_0_0_0100},
      '{1'b1, 1'b1, 4'h9, 4'h8, 2'b10, 1'b0, 1'b1, 1'b0, 9'b1_0_1_0_1_1000},
      '{1'b1, 1'b1, 4'hB, 4'h3, 2'b01, 1'b0, 1'b0, 1'b1, 9'b1_0_0_1_1_1011},
      '{1'b1, 1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b1_0_1_0_1_1011},
      '{1'b1, 1'b1, 4'h4, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 9'b1_1_0_0_1_1011},
      '{1'b1, 1'b1, 4'h4, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 9'b1_0_0_0_0_1011},
      '{1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b1_0_1_0_1_1011},
      '{1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b0_0_0_0_0_1011},
      '{1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 9'b1_1_0_0_1_1011},
      '{1'b0, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 9'b0_0_0_0_0_1011},
      '{1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 9'b1_0_0_0_0_1011}
    };

    model_reset();
    #12;
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_rdy", 32'(in_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].a, tbl[i].fw,
            tbl[i].p, tbl[i].rw, tbl[i].mw);
      check($sformatf("tbl%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // stall: held output blocks a new bundle until out_ready rises
    apply(1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("pre_stall", 32'(outs()), 32'(9'b1_0_1_0_1_1011));
    apply(1'b1, 1'b0, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1);
    check("stall_hold", 32'(outs()), 32'(9'b1_0_1_0_1_1011));
    out_ready = 1'b0;
    #1;
    check("stall_rdy", 32'(in_ready), 32'h0);
    apply(1'b1, 1'b1, 4'hE, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1);
    check("stall_release", 32'(outs()), 32'(9'b1_0_0_1_1_1111));

    // asynchronous reset in the middle of a cycle
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(outs()), 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef COND_STATS_EN
    for (int i = 0; i < 5; i++)
      apply(1'b1, 1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++)
      apply(1'b1, 1'b1, 4'hF, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("exec_sat", 32'(exec_count), 32'd3);
    check("skip_cnt", 32'(skip_count), 32'd2);
`endif

    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            4'($urandom), 4'($urandom), 2'($urandom),
            $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
